multiple_seq: RTL

Multi-cycle sequencer for Thumb LDM/STM/PUSH/POP in the Cortex-M0 core. It sits beside the IF/ID pipeline register and owns the `multiple_pulse`/`multiple_stable` pair that register carries. It walks the decoded register list one register per cycle, emitting register index and byte offset to the execute/memory stage. While the sequence runs it holds the fetch side stalled.

---
 rtl/multiple_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/multiple_seq.sv
// multiple_seq: walks a Thumb LDM/STM/PUSH/POP register list one register
// per cycle, presenting register number and byte offset to execute/memory,
// and holding the fetch side stalled until the final transfer.
module multiple_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] reg_list,
    input  logic       is_load,
    input  logic       flush,
    output logic       busy,
    output logic       multiple_pulse,
    output logic       multiple_stable,
    output logic       xfer_valid,
    output logic [3:0] xfer_reg,
    output logic       xfer_load,
    output logic [5:0] offset,
    output logic       last,
    output logic [5:0] total_bytes,
    output logic       stall_if
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] remaining_q, remaining_d;
    logic [5:0] offset_q, offset_d;
    logic       load_q, load_d;
    logic       first_q, first_d;
    logic [5:0] total_q, total_d;

    logic [8:0] lowest_bit;
    logic [3:0] lowest_idx;
    logic [3:0] list_count;
    logic       rem_single;
    logic       run;

    // Two's-complement trick isolates the lowest set bit of the pending list.
    assign lowest_bit = remaining_q & (~remaining_q + 9'd1);

    // Exactly one bit left means this cycle carries the final transfer.
    assign rem_single = (remaining_q != 9'd0) &&
                        ((remaining_q & (remaining_q - 9'd1)) == 9'd0);

    assign run = (state_q == S_RUN);

    // Priority encoder: index of the lowest pending register bit.
    always_comb begin
        lowest_idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (remaining_q[i]) begin
                lowest_idx = 4'(i);
            end
        end
    end

    // Number of registers in the incoming list, used for the writeback size.
    always_comb begin
        list_count = 4'd0;
        for (int i = 0; i < 9; i++) begin
            list_count = list_count + {3'b000, reg_list[i]};
        end
    end

    // Next-state logic; flush aborts from any state and beats start.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        offset_d    = offset_q;
        load_d      = load_q;
        first_d     = first_q;
        total_d     = total_q;

        if (flush) begin
            state_d     = S_IDLE;
            remaining_d = 9'd0;
            offset_d    = 6'd0;
            load_d      = 1'b0;
            first_d     = 1'b0;
            total_d     = 6'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // An empty list is not a sequence; stay idle.
                    if (start && (reg_list != 9'd0)) begin
                        state_d     = S_RUN;
                        remaining_d = reg_list;
                        offset_d    = 6'd0;
                        first_d     = 1'b1;
                        load_d      = is_load;
                        total_d     = {list_count, 2'b00};
                    end
                end
                S_RUN: begin
                    // start is ignored here: the decoder is held by stall_if.
                    remaining_d = remaining_q & ~lowest_bit;
                    offset_d    = offset_q + 6'd4;
                    first_d     = 1'b0;
                    if (rem_single) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register; reset behaves like a flush and overrides all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= 9'd0;
            offset_q    <= 6'd0;
            load_q      <= 1'b0;
            first_q     <= 1'b0;
            total_q     <= 6'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            offset_q    <= offset_d;
            load_q      <= load_d;
            first_q     <= first_d;
            total_q     <= total_d;
        end
    end

    // Outputs are gated to zero whenever no sequence is running.
    always_comb begin
        busy            = run;
        multiple_stable = run;
        xfer_valid      = run;
        multiple_pulse  = run & first_q;
        xfer_load       = run & load_q;
        offset          = run ? offset_q : 6'd0;
        total_bytes     = run ? total_q  : 6'd0;
        last            = run & rem_single;
        stall_if        = run & ~rem_single;
        xfer_reg        = 4'd0;
        if (run) begin
            // Bit 8 is LR for stores and PC for loads.
            if (lowest_idx == 4'd8) begin
                xfer_reg = load_q ? 4'd15 : 4'd14;
            end else begin
                xfer_reg = lowest_idx;
            end
        end
    end

endmodule
